wam_game_core: RTL

Parametrised round engine for the whack-a-mole game: it sequences lit/gap intervals, picks a target light from an external random source and judges keypad presses as hits or misses. It also tracks score, flicks, misses and remaining time, and detects game over for four modes: normal, timed, deathmatch and level continuity. It sits between the LFSR/keypad controller and the HEX/LED display logic, replacing the ad-hoc game FSM in the top level.

---
 rtl/wam_game_core.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/wam_game_core.sv
// Whack-a-mole round engine: sequences gap/lit intervals, judges key presses,
// tracks score/flicks/misses/time and detects game over for four game modes.
module wam_game_core #(
    parameter int unsigned N_LIGHTS    = 9,
    parameter int unsigned POS_W       = 4,
    parameter int unsigned T_ON        = 100_000_000,
    parameter int unsigned T_GAP       = 100_000_000,
    parameter int unsigned SEC_CYCLES  = 50_000_000,
    parameter int unsigned TIMED_SECS  = 60,
    parameter int unsigned NORMAL_HITS = 25,
    parameter int unsigned EXT_HITS    = 50,
    parameter int unsigned LEVEL_UP    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play,
    input  logic [1:0]          mode,
    input  logic [1:0]          level,
    input  logic                extended,
    input  logic [POS_W-1:0]    rnd,
    input  logic                key_valid,
    input  logic [POS_W-1:0]    key,
    output logic [N_LIGHTS-1:0] lights,
    output logic [6:0]          score,
    output logic [6:0]          flicks,
    output logic [6:0]          misses,
    output logic [5:0]          time_left,
    output logic [1:0]          cur_level,
    output logic [6:0]          max_hits,
    output logic [1:0]          state,
    output logic                game_over
);

    localparam int unsigned T_MAX = (T_ON > T_GAP) ? T_ON : T_GAP;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);
    localparam int unsigned SEC_W = $clog2(SEC_CYCLES + 1);
    localparam int unsigned LVL_W = $clog2(LEVEL_UP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_LIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [N_LIGHTS-1:0]   lights_q, lights_d;
    logic [6:0]            score_q, score_d, flicks_q, flicks_d, misses_q, misses_d;
    logic [6:0]            max_hits_q, max_hits_d;
    logic [5:0]            time_left_q, time_left_d;
    logic [1:0]            cur_level_q, cur_level_d, mode_q, mode_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEC_W-1:0]      sec_q, sec_d;
    logic [LVL_W-1:0]      lvl_cnt_q, lvl_cnt_d;
    logic [POS_W-1:0]      pos_q, pos_d, pick;
    logic                  prev_valid_q, prev_valid_d;

    logic [CNT_W-1:0]      gap_len, on_len;
    logic [CNT_W:0]        cnt_inc;
    logic                  gap_done, lit_done, in_game, sec_tick, time_zero, hit, resolve;

    function automatic logic [6:0] inc_sat(input logic [6:0] v, input logic [6:0] lim);
        return (v >= lim) ? v : v + 7'd1;
    endfunction

    assign gap_len   = CNT_W'(T_GAP >> cur_level_q);
    assign on_len    = cur_level_q[1] ? CNT_W'(T_ON >> (cur_level_q - 2'd1))
                                      : CNT_W'(T_ON >> cur_level_q);
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign gap_done  = cnt_inc >= {1'b0, gap_len};
    assign lit_done  = cnt_inc >= {1'b0, on_len};
    assign in_game   = (state_q == S_GAP) || (state_q == S_LIT);
    assign sec_tick  = in_game && (mode_q == 2'd1) && (sec_q == SEC_W'(SEC_CYCLES - 1));
    assign time_zero = sec_tick && (time_left_q == 6'd1) && !play;
    assign hit       = key_valid && (key == pos_q);

    // Avoid showing the same light twice in a row.
    always_comb begin
        pick = POS_W'(32'(rnd) % N_LIGHTS);
        if (prev_valid_q && (pick == pos_q))
            pick = (pick == POS_W'(N_LIGHTS - 1)) ? '0 : pick + POS_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        lights_d     = lights_q;
        score_d      = score_q;
        flicks_d     = flicks_q;
        misses_d     = misses_q;
        max_hits_d   = max_hits_q;
        time_left_d  = time_left_q;
        cur_level_d  = cur_level_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        sec_d        = sec_q;
        lvl_cnt_d    = lvl_cnt_q;
        pos_d        = pos_q;
        prev_valid_d = prev_valid_q;
        resolve      = 1'b0;

        if (in_game && (mode_q == 2'd1) && !play) begin
            sec_d = sec_tick ? '0 : sec_q + SEC_W'(1);
            if (sec_tick)
                time_left_d = time_left_q - 6'd1;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (play) begin
                    state_d      = S_GAP;
                    lights_d     = '0;
                    score_d      = '0;
                    flicks_d     = '0;
                    misses_d     = '0;
                    time_left_d  = 6'(TIMED_SECS);
                    mode_d       = mode;
                    max_hits_d   = extended ? 7'(EXT_HITS) : 7'(NORMAL_HITS);
                    cur_level_d  = (mode == 2'd3) ? 2'd0 : level;
                    cnt_d        = '0;
                    sec_d        = '0;
                    lvl_cnt_d    = '0;
                    prev_valid_d = 1'b0;
                end
            end
            S_GAP: begin
                if (play || time_zero) begin
                    state_d  = S_OVER;
                    lights_d = '0;
                end else if (gap_done) begin
                    state_d      = S_LIT;
                    lights_d     = N_LIGHTS'(1) << pick;
                    pos_d        = pick;
                    prev_valid_d = 1'b1;
                    flicks_d     = inc_sat(flicks_q, 7'd127);
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LIT: begin
                if (play) begin
                    state_d  = S_OVER;
                    lights_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (hit) begin
                        score_d = inc_sat(score_q, 7'd99);
                        resolve = 1'b1;
                        if (mode_q == 2'd3) begin
                            if (lvl_cnt_q == LVL_W'(LEVEL_UP - 1)) begin
                                lvl_cnt_d   = '0;
                                cur_level_d = (cur_level_q == 2'd3) ? 2'd3 : cur_level_q + 2'd1;
                            end else begin
                                lvl_cnt_d = lvl_cnt_q + LVL_W'(1);
                            end
                        end
                    end else if (key_valid || lit_done) begin
                        misses_d = inc_sat(misses_q, 7'd99);
                        resolve  = lit_done || (mode_q == 2'd2);
                    end
                    if (resolve) begin
                        lights_d = '0;
                        cnt_d    = '0;
                        if ((mode_q == 2'd2) && !hit)
                            state_d = S_OVER;
                        else if (((mode_q == 2'd0) || (mode_q == 2'd3)) && (flicks_q == max_hits_q))
                            state_d = S_OVER;
                        else
                            state_d = S_GAP;
                    end
                    // A resolution in the final second is still counted before ending.
                    if (time_zero) begin
                        state_d  = S_OVER;
                        lights_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lights_q     <= '0;
            score_q      <= '0;
            flicks_q     <= '0;
            misses_q     <= '0;
            max_hits_q   <= 7'(NORMAL_HITS);
            time_left_q  <= 6'(TIMED_SECS);
            cur_level_q  <= '0;
            mode_q       <= '0;
            cnt_q        <= '0;
            sec_q        <= '0;
            lvl_cnt_q    <= '0;
            pos_q        <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lights_q     <= lights_d;
            score_q      <= score_d;
            flicks_q     <= flicks_d;
            misses_q     <= misses_d;
            max_hits_q   <= max_hits_d;
            time_left_q  <= time_left_d;
            cur_level_q  <= cur_level_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            sec_q        <= sec_d;
            lvl_cnt_q    <= lvl_cnt_d;
            pos_q        <= pos_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign lights    = lights_q;
    assign score     = score_q;
    assign flicks    = flicks_q;
    assign misses    = misses_q;
    assign time_left = time_left_q;
    assign cur_level = cur_level_q;
    assign max_hits  = max_hits_q;
    assign state     = state_q;
    assign game_over = (state_q == S_OVER);

endmodule
